// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
//   Single-clock scan controller for a 4-digit common-anode seven-segment
//   display. A free-running prescaler defines one slot per digit. Each slot
//   opens with a blank window, during which all anodes are off, to avoid
//   ghosting. New values are parked in a shadow register through a
//   valid/ready handshake. They become active only at a frame boundary, so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   clk_fast   : system clock, the only clock
//   rst_n      : asynchronous active-low reset
//   upd_valid  : update request (upd_value/upd_dp valid while high)
//   upd_value  : four hex digits, [3:0] = digit 0 (rightmost)
//   upd_dp     : decimal points, bit i = digit i, 1 = lit
//   lzb_en     : leading-zero blanking enable (live level)
//   upd_ready  : shadow slot free
//   an         : anodes, active-low, an[i] = digit i
//   seg        : segments, active-low, seg[0]=a .. seg[6]=g
//   dp_n       : decimal point, active-low
//   frame_done : one-cycle pulse per frame boundary
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int DIV_W        = 18,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic        clk_fast,
    input  logic        rst_n,
    input  logic        upd_valid,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dp,
    input  logic        lzb_en,
    output logic        upd_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [1:0]       dig;
    logic [15:0]      act_val;
    logic [15:0]      pend_val;
    logic [3:0]       act_dp;
    logic [3:0]       pend_dp;
    logic             pend_v;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic             drive;
    logic             lz_blank;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;

    assign tick      = &cnt;
    assign boundary  = tick && (dig == 2'd3);
    assign upd_ready = ~pend_v;
    assign accept    = upd_valid && ~pend_v;
    assign drive     = (cnt >= BLANK_END);
    assign nib       = act_val[{dig, 2'b00} +: 4];

    // Digit d > 0 goes dark when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (dig)
            2'd1:    lz_blank = (act_val[15:4]  == 12'h000);
            2'd2:    lz_blank = (act_val[15:8]  == 8'h00);
            2'd3:    lz_blank = (act_val[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank && lzb_en;
    end

    // Hex to active-low segments, g..a order.
    always_comb begin
        seg_dec = 7'h7F;
        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dig        <= 2'd0;
            act_val    <= 16'h0000;
            act_dp     <= 4'h0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_v     <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // cnt wraps to 0 on tick by natural overflow.
            cnt <= cnt + CNT_ONE;
            if (tick) dig <= dig + 2'd1;

            // The shadow is full on a boundary with pend_v set, so a
            // same-cycle accept cannot happen then. A capture on a boundary
            // with pend_v clear waits for the next boundary.
            if (boundary && pend_v) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pend_v  <= 1'b0;
            end else if (accept) begin
                pend_val <= upd_value;
                pend_dp  <= upd_dp;
                pend_v   <= 1'b1;
            end

            frame_done <= boundary;

            if (drive && !lz_blank) begin
                an   <= ~(4'b0001 << dig);
                seg  <= seg_dec;
                dp_n <= ~act_dp[dig];
            end else begin
                an   <= 4'hF;
                seg  <= 7'h7F;
                dp_n <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl
//   Directed bench for disp_scan_ctrl with DIV_W=4 and BLANK_CYCLES=3.
//   One slot is 16 cycles and one frame is 64 cycles. Every frame is checked
//   cycle by cycle against hand-written per-digit anode, segment and dp
//   values. A one-flag model of the shadow register predicts upd_ready.
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;
    logic        clk_fast  = 1'b0;
    logic        rst_n     = 1'b1;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_value = 16'h0000;
    logic [3:0]  upd_dp    = 4'h0;
    logic        lzb_en    = 1'b0;
    logic        upd_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cur_s    = 0;

    // Driver and model state.
    logic        b_pend    = 1'b0;
    logic        have_next = 1'b0;
    logic [15:0] next_val  = 16'h0000;
    logic [3:0]  next_dp   = 4'h0;
    int          sched_step = -1;
    logic [15:0] sched_val  = 16'h0000;
    logic [3:0]  sched_dp   = 4'h0;

    // Per-frame segment images, {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] S_0000  = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] S_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] S_ABCD  = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] S_0040  = {7'h40, 7'h40, 7'h19, 7'h40};
    localparam logic [27:0] S_5555  = {7'h12, 7'h12, 7'h12, 7'h12};
    localparam logic [27:0] S_Z_LZB = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] S_40LZB = {7'h7F, 7'h7F, 7'h19, 7'h40};

    disp_scan_ctrl #(.DIV_W(4), .BLANK_CYCLES(3)) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_value  (upd_value),
        .upd_dp     (upd_dp),
        .lzb_en     (lzb_en),
        .upd_ready  (upd_ready),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", tag, cur_s, got, exp);
        end
    endtask

    // One clock from negedge to negedge. The driver drops upd_valid after an
    // accepted transfer, or loads the queued follow-up request instead.
    task automatic step(input logic bnd);
        logic acc;
        acc = upd_valid && !b_pend;
        @(posedge clk_fast);
        #1;
        if (bnd && b_pend) b_pend = 1'b0;
        else if (acc)      b_pend = 1'b1;
        if (acc) begin
            if (have_next) begin
                upd_value = next_val;
                upd_dp    = next_dp;
                have_next = 1'b0;
            end else begin
                upd_valid = 1'b0;
            end
        end
        @(negedge clk_fast);
    endtask

    // Called aligned so that the next edge shows slot 0, cnt 0.
    // It ends on the negedge where frame_done is high.
    task automatic check_frame(input string nm, input logic [15:0] an_e,
                               input logic [27:0] seg_e, input logic [3:0] dpn_e);
        int slot;
        int pos;
        for (int s = 1; s <= 64; s++) begin
            if (s == sched_step) begin
                upd_valid  = 1'b1;
                upd_value  = sched_val;
                upd_dp     = sched_dp;
                sched_step = -1;
            end
            step(s == 64);
            cur_s = s;
            slot  = (s - 1) / 16;
            pos   = (s - 1) % 16;
            if (pos < 3) begin
                chk({nm, "/an"},  32'(an),   32'h0000000F);
                chk({nm, "/seg"}, 32'(seg),  32'h0000007F);
                chk({nm, "/dp"},  32'(dp_n), 32'h00000001);
            end else begin
                chk({nm, "/an"},  32'(an),   32'(an_e[slot*4 +: 4]));
                chk({nm, "/seg"}, 32'(seg),  32'(seg_e[slot*7 +: 7]));
                chk({nm, "/dp"},  32'(dp_n), 32'(dpn_e[slot]));
            end
            chk({nm, "/fd"},  32'(frame_done), (s == 64) ? 32'd1 : 32'd0);
            chk({nm, "/rdy"}, 32'(upd_ready),  32'(!b_pend));
        end
    endtask

    // Reset asserted between clock edges. A request is held during reset and
    // must be ignored. Reset is released on a negedge, which aligns the bench
    // to the start of a frame.
    task automatic async_reset();
        @(posedge clk_fast);
        #2;
        rst_n = 1'b0;
        #1;
        cur_s = 0;
        chk("arst/an",  32'(an),         32'h0000000F);
        chk("arst/seg", 32'(seg),        32'h0000007F);
        chk("arst/dp",  32'(dp_n),       32'h00000001);
        chk("arst/fd",  32'(frame_done), 32'h00000000);
        upd_valid = 1'b1;
        upd_value = 16'hFFFF;
        upd_dp    = 4'hF;
        have_next = 1'b0;
        repeat (5) @(negedge clk_fast);
        chk("arst/rdy", 32'(upd_ready), 32'h00000001);
        upd_valid  = 1'b0;
        b_pend     = 1'b0;
        sched_step = -1;
        rst_n      = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_fast);
        chk("rst/an",  32'(an),         32'h0000000F);
        chk("rst/seg", 32'(seg),        32'h0000007F);
        chk("rst/dp",  32'(dp_n),       32'h00000001);
        chk("rst/fd",  32'(frame_done), 32'h00000000);
        chk("rst/rdy", 32'(upd_ready),  32'h00000001);
        rst_n = 1'b1;
        repeat (20) step(1'b0);

        // Reset in mid-scan. The first frame after release shows 0000.
        async_reset();
        check_frame("rst0", 16'h7BDE, S_0000, 4'hF);

        // Scan order and decode for 0x1234 with the dp on digit 0.
        sched_step = 1; sched_val = 16'h1234; sched_dp = 4'b0001;
        check_frame("pre1234", 16'h7BDE, S_0000, 4'hF);
        check_frame("d1234",   16'h7BDE, S_1234, 4'b1110);

        // Mid-frame handshake. The old value holds until the boundary.
        sched_step = 20; sched_val = 16'hABCD; sched_dp = 4'h0;
        check_frame("oldval", 16'h7BDE, S_1234, 4'b1110);
        check_frame("dABCD",  16'h7BDE, S_ABCD, 4'hF);

        // Back-to-back: 0x0040 is accepted. 0x5555 waits while the shadow
        // is full and is accepted right after the boundary.
        upd_valid = 1'b1; upd_value = 16'h0040; upd_dp = 4'h0;
        have_next = 1'b1; next_val = 16'h5555; next_dp = 4'h0;
        check_frame("holdABCD", 16'h7BDE, S_ABCD, 4'hF);
        check_frame("d0040",    16'h7BDE, S_0040, 4'hF);

        // Boundary collision: a capture on the boundary tick is shown one
        // frame later.
        sched_step = 64; sched_val = 16'h0000; sched_dp = 4'h0;
        check_frame("d5555a", 16'h7BDE, S_5555, 4'hF);
        check_frame("d5555b", 16'h7BDE, S_5555, 4'hF);
        check_frame("d0000",  16'h7BDE, S_0000, 4'hF);

        // Leading-zero blanking.
        lzb_en = 1'b1;
        check_frame("lzb0000", 16'hFFFE, S_Z_LZB, 4'hF);
        sched_step = 1; sched_val = 16'h0040; sched_dp = 4'h0;
        check_frame("lzbpre",  16'hFFFE, S_Z_LZB, 4'hF);
        check_frame("lzb0040", 16'hFFDE, S_40LZB, 4'hF);

        // Reset with a pending update discards it.
        upd_valid = 1'b1; upd_value = 16'hFFFF; upd_dp = 4'hF;
        step(1'b0);
        async_reset();
        check_frame("post0", 16'hFFFE, S_Z_LZB, 4'hF);
        check_frame("post1", 16'hFFFE, S_Z_LZB, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the Basys3 4-digit common-anode seven-segment display. It replaces the divided-clock refresh scheme with a single-clock design: a prescaler tick steps the active digit, and each digit slot opens with an anti-ghosting blank window. Updates arrive through a valid/ready handshake into a shadow register and are applied only at frame boundaries, so the display never tears. It sits between the DisplayTop data sources and the board pins.

## Interface
- DIV_W, 18: prescaler width; one digit slot lasts 2^DIV_W clk_fast cycles (~381 Hz step at 100 MHz).
- BLANK_CYCLES, 1024: cycles at the start of each slot with all anodes off; must be < 2^DIV_W.
- clk_fast  in  1  system clock (100 MHz); the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  update request; upd_value/upd_dp are valid while high.
- upd_value  in  16  four hex digits; [3:0] = digit 0 (rightmost).
- upd_dp  in  4  decimal points, bit i = digit i, 1 = lit.
- lzb_en  in  1  leading-zero blanking enable (level, sampled live).
- upd_ready  out  1  shadow slot free; transfer occurs when upd_valid & upd_ready.
- an  out  4  anodes, active-low, an[i] = digit i.
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g.
- dp_n  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at every frame boundary.

## Operation
- State: cnt (DIV_W bits), dig (2 bits), act_val/act_dp (active), pend_val/pend_dp/pend_v (shadow).
- cnt increments every cycle. tick = (cnt == 2^DIV_W−1). On tick, cnt wraps to 0 and dig advances 0→1→2→3→0.
- Phase: BLANK when cnt < BLANK_CYCLES, DRIVE otherwise.
- Frame boundary = tick with dig==3. On that cycle: frame_done=1; if pend_v then act_* ← pend_*, pend_v ← 0.
- upd_ready = ~pend_v (combinational). On upd_valid & upd_ready: pend_* ← upd_*, pend_v ← 1.
- A transfer accepted on a boundary cycle (pend_v was 0) is applied at the next boundary, not the current one.
- While pend_v=1, upd_valid is ignored (no overwrite); the requester holds its value.
- Decode: standard hex 0–F active-low (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E in g..a order).
- Leading-zero blank: when lzb_en=1, digit d>0 is blanked if act_val nibbles d..3 are all zero. Digit 0 is never blanked.
- Outputs in DRIVE for unblanked digit d: an = ~(1<<d), seg = decode(nibble d), dp_n = ~act_dp[d]. In BLANK phase or for a blanked digit: an=4'hF, seg=7'h7F, dp_n=1.

## Timing
- an, seg, dp_n, frame_done are registered: they reflect cnt/dig/act_* state of the previous cycle (latency 1).
- Reset (async assert, sync-safe release): cnt=0, dig=0, act_val=0, act_dp=0, pend_v=0, an=4'hF, seg=7'h7F, dp_n=1, frame_done=0. upd_ready reads 1 but no transfer is taken while rst_n=0.
- First DRIVE output for digit 0 appears BLANK_CYCLES+1 cycles after reset release; it shows "0" with act_val=0.
- Frame period = 4·2^DIV_W cycles; frame_done is high for exactly 1 cycle per frame, 1 cycle after the boundary tick.
- Update-to-display latency: up to one frame plus 1 cycle after the handshake.
- Reset mid-slot or with pend_v=1: the pending update is discarded, and outputs blank immediately (asynchronously).
- lzb_en changes take effect on the next registered output cycle; no frame alignment.

## Test plan
- Reset: hold rst_n=0 for 5 cycles mid-scan -> an=F, seg=7F, dp_n=1, frame_done=0 immediately. After release with DIV_W=4, BLANK=3: an=F for cycles 1–3, then an=E, seg=40.
- Scan order (DIV_W=4, BLANK=3): after upd 0x1234/dp=0001 is applied -> an sequence E,D,B,7 with 16 cycles per slot. Each slot is blank for 3 cycles. Seg values 4→19, 3→30, 2→24, 1→79. dp_n=0 only on digit 0.
- Handshake: upd_valid with 0xABCD at mid-frame -> upd_ready falls the next cycle. Old value is displayed until the boundary. frame_done pulses, then the new value is displayed and upd_ready=1.
- Back-to-back: second upd_valid (0x5555) while pending -> not accepted, 0xABCD is displayed. After ready returns, it is accepted and applied at the following boundary.
- Boundary collision: upd_valid on the exact dig==3 tick with pend_v=0 -> captured. It is not applied until the next frame_done.
- LZB: value 0x0040, lzb_en=1 -> digits 3 and 2 are blank (an stays F in their slots), digit 1 shows "4", digit 0 shows "0". With value 0x0000, only digit 0 is lit. With lzb_en=0, all four digits are lit.
